// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types for the execute stage
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL
    } aluop_e;

    typedef enum logic [1:0] {
        SRC_RT, SRC_IMM, SRC_SHAMT, SRC_ZERO
    } alusrc_e;

    typedef enum logic [1:0] {
        IDLE, RUN, DONE
    } mul_state_e;

    localparam int FWD_NONE = 0;

endpackage

// File: rtl/execute_mc_if.sv
// rtl/execute_mc_if.sv - decode/forwarding/result bundle of the execute stage
interface execute_mc_if #(
    parameter int DW   = 32,
    parameter int CW   = 8,
    parameter int NFWD = 2
);
    localparam int SW = $clog2(NFWD + 1);

    logic               flush;
    logic               exen;
    logic               id_valid;
    logic [DW-1:0]      id_rs;
    logic [DW-1:0]      id_rt;
    logic [DW-1:0]      id_imm;
    logic [DW-1:0]      id_shamt;
    logic [1:0]         id_alusrc;
    logic [3:0]         id_aluop;
    logic [CW-1:0]      id_ctrl;
    logic [DW-1:0]      id_npc;
    logic [31:0]        id_instr;
    logic [NFWD*DW-1:0] fwd_data;
    logic [SW-1:0]      fwd_selA;
    logic [SW-1:0]      fwd_selB;
    logic               ex_valid;
    logic               ex_busy;
    logic [DW-1:0]      ex_result;
    logic               ex_zero;
    logic [DW-1:0]      ex_store;
    logic [CW-1:0]      ex_ctrl;
    logic [DW-1:0]      ex_npc;
    logic [31:0]        ex_instr;

    modport master (
        output flush, exen, id_valid, id_rs, id_rt, id_imm, id_shamt, id_alusrc,
               id_aluop, id_ctrl, id_npc, id_instr, fwd_data, fwd_selA, fwd_selB,
        input  ex_valid, ex_busy, ex_result, ex_zero, ex_store, ex_ctrl, ex_npc, ex_instr
    );

    modport slave (
        input  flush, exen, id_valid, id_rs, id_rt, id_imm, id_shamt, id_alusrc,
               id_aluop, id_ctrl, id_npc, id_instr, fwd_data, fwd_selA, fwd_selB,
        output ex_valid, ex_busy, ex_result, ex_zero, ex_store, ex_ctrl, ex_npc, ex_instr
    );

endinterface

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational single-cycle ALU (multiply is handled by the stage)
module exec_alu
    import exec_pkg::*;
#(
    parameter int DW = 32
) (
    input  aluop_e        i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_result
);
    localparam int SHW = $clog2(DW);

    logic [SHW-1:0] w_sh;
    assign w_sh = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_SLL:  o_result = i_a << w_sh;
            ALU_SRL:  o_result = i_a >> w_sh;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_sh);
            ALU_SLT:  o_result = {{(DW-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(DW-1){1'b0}}, (i_a < i_b)};
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/execute_mc.sv
// rtl/execute_mc.sv - ID/EX register, forwarding operand mux, ALU and multi-cycle multiply
module execute_mc
    import exec_pkg::*;
#(
    parameter int DW      = 32,
    parameter int CW      = 8,
    parameter int NFWD    = 2,
    parameter int MUL_LAT = 4
) (
    input logic         CLK,
    input logic         RST,
    execute_mc_if.slave bus
);
    localparam int SW    = $clog2(NFWD + 1);
    localparam int CNTW  = $clog2(MUL_LAT + 2);
    localparam bit MULTI = (MUL_LAT > 1);

    logic            r_valid;
    logic [DW-1:0]   r_rs, r_rt, r_imm, r_shamt, r_npc;
    alusrc_e         r_alusrc;
    aluop_e          r_aluop;
    logic [CW-1:0]   r_ctrl;
    logic [31:0]     r_instr;
    mul_state_e      r_state, w_state_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    logic [DW-1:0]   r_mul_a, r_mul_b;

    logic            w_busy, w_load, w_mul_held, w_capture;
    logic [DW-1:0]   w_a, w_rtv, w_b, w_alu_res, w_result;

    assign w_mul_held = r_valid && (r_aluop == ALU_MUL);
    assign w_busy     = (MULTI && w_mul_held && (r_state == IDLE)) || (r_state == RUN);
    assign w_load     = bus.exen && !w_busy;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST || bus.flush) begin
            r_valid  <= 1'b0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_imm    <= '0;
            r_shamt  <= '0;
            r_alusrc <= SRC_RT;
            r_aluop  <= ALU_ADD;
            r_ctrl   <= '0;
            r_npc    <= '0;
            r_instr  <= '0;
        end else if (w_load) begin
            r_valid  <= bus.id_valid;
            r_rs     <= bus.id_rs;
            r_rt     <= bus.id_rt;
            r_imm    <= bus.id_imm;
            r_shamt  <= bus.id_shamt;
            r_alusrc <= alusrc_e'(bus.id_alusrc);
            r_aluop  <= aluop_e'(bus.id_aluop);
            r_ctrl   <= bus.id_ctrl;
            r_npc    <= bus.id_npc;
            r_instr  <= bus.id_instr;
        end
    end

    // Out-of-range selects fall back to the registered operand.
    always_comb begin
        w_a   = r_rs;
        w_rtv = r_rt;
        for (int k = 0; k < NFWD; k++) begin
            if (bus.fwd_selA == SW'(k + 1)) w_a   = bus.fwd_data[k*DW +: DW];
            if (bus.fwd_selB == SW'(k + 1)) w_rtv = bus.fwd_data[k*DW +: DW];
        end
        case (r_alusrc)
            SRC_RT:    w_b = w_rtv;
            SRC_IMM:   w_b = r_imm;
            SRC_SHAMT: w_b = r_shamt;
            default:   w_b = '0;
        endcase
    end

    exec_alu #(.DW(DW)) u_alu (
        .i_op     (r_aluop),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_alu_res)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_mul_a <= w_a;
                r_mul_b <= w_b;
            end
        end
    end

    // Operands are captured on the entry edge so later forwarding changes cannot disturb the product.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        if (bus.flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: if (MULTI && w_mul_held) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = CNTW'(MUL_LAT - 1);
                    w_state_nxt = (MUL_LAT <= 2) ? DONE : RUN;
                end
                RUN: begin
                    w_cnt_nxt = r_cnt - CNTW'(1);
                    if (r_cnt == CNTW'(2)) w_state_nxt = DONE;
                end
                DONE: if (w_load) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_result = (r_aluop != ALU_MUL) ? w_alu_res :
                      (MULTI ? r_mul_a * r_mul_b : w_a * w_b);

    assign bus.ex_valid  = r_valid && !w_busy;
    assign bus.ex_busy   = w_busy;
    assign bus.ex_result = w_result;
    assign bus.ex_zero   = (w_result == '0);
    assign bus.ex_store  = w_rtv;
    assign bus.ex_ctrl   = r_ctrl;
    assign bus.ex_npc    = r_npc;
    assign bus.ex_instr  = r_instr;

endmodule

// File: tb/tb_execute_mc.sv
// tb/tb_execute_mc.sv - directed scoreboard bench for two execute_mc configurations
module tb_execute_mc;
    import exec_pkg::*;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    execute_mc_if #(.DW(32), .CW(8), .NFWD(2)) a0 ();
    execute_mc_if #(.DW(16), .CW(8), .NFWD(3)) a1 ();

    execute_mc #(.DW(32), .CW(8), .NFWD(2), .MUL_LAT(4)) u0 (
        .CLK (CLK),
        .RST (RST),
        .bus (a0.slave)
    );

    execute_mc #(.DW(16), .CW(8), .NFWD(3), .MUL_LAT(1)) u1 (
        .CLK (CLK),
        .RST (RST),
        .bus (a1.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb0(input string tag);
        logic [63:0] e;
        chk({tag, "_valid"}, 64'(a0.ex_valid), 64'd1);
        checks++;
        assert (q0.size() > 0) else begin
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk({tag, "_res"},  64'(a0.ex_result), e);
            chk({tag, "_zero"}, 64'(a0.ex_zero), 64'(e == 64'd0));
        end
    endtask

    task automatic sb1(input string tag);
        logic [63:0] e;
        chk({tag, "_valid"}, 64'(a1.ex_valid), 64'd1);
        checks++;
        assert (q1.size() > 0) else begin
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk({tag, "_res"}, 64'(a1.ex_result), e);
        end
    endtask

    task automatic load0(input aluop_e op, input alusrc_e src, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm,
                         input logic [31:0] sh, input logic [7:0] ctrl);
        a0.id_valid  = 1'b1;
        a0.id_aluop  = op;
        a0.id_alusrc = src;
        a0.id_rs     = rs;
        a0.id_rt     = rt;
        a0.id_imm    = imm;
        a0.id_shamt  = sh;
        a0.id_ctrl   = ctrl;
        a0.id_npc    = 32'h400 + {24'h0, ctrl};
        a0.id_instr  = {24'hC0FFEE, ctrl};
        a0.exen      = 1'b1;
    endtask

    task automatic load1(input aluop_e op, input logic [15:0] rs, input logic [15:0] rt);
        a1.id_valid  = 1'b1;
        a1.id_aluop  = op;
        a1.id_alusrc = SRC_RT;
        a1.id_rs     = rs;
        a1.id_rt     = rt;
        a1.exen      = 1'b1;
    endtask

    initial begin
        int busy_n;
        checks = 0;
        errors = 0;
        RST    = 1'b1;
        {a0.flush, a0.exen, a0.id_valid, a0.id_rs, a0.id_rt, a0.id_imm, a0.id_shamt} = '0;
        {a0.id_alusrc, a0.id_aluop, a0.id_ctrl, a0.id_npc, a0.id_instr} = '0;
        {a0.fwd_data, a0.fwd_selA, a0.fwd_selB} = '0;
        {a1.flush, a1.exen, a1.id_valid, a1.id_rs, a1.id_rt, a1.id_imm, a1.id_shamt} = '0;
        {a1.id_alusrc, a1.id_aluop, a1.id_ctrl, a1.id_npc, a1.id_instr} = '0;
        {a1.fwd_data, a1.fwd_selA, a1.fwd_selB} = '0;
        repeat (2) step();
        RST = 1'b0;
        step();

        chk("rst_valid",  64'(a0.ex_valid),  64'd0);
        chk("rst_busy",   64'(a0.ex_busy),   64'd0);
        chk("rst_result", 64'(a0.ex_result), 64'd0);
        chk("rst_zero",   64'(a0.ex_zero),   64'd1);
        chk("rst_ctrl",   64'(a0.ex_ctrl),   64'd0);
        chk("rst_npc",    64'(a0.ex_npc),    64'd0);
        chk("rst_store",  64'(a0.ex_store),  64'd0);
        chk("rst16_zero", 64'(a1.ex_zero),   64'd1);

        load0(ALU_ADD, SRC_IMM, 32'd5, 32'd0, 32'd7, 32'd0, 8'hA5);
        q0.push_back(64'd12);
        step();
        a0.exen = 1'b0;
        sb0("add");
        chk("add_ctrl",  64'(a0.ex_ctrl),  64'hA5);
        chk("add_npc",   64'(a0.ex_npc),   64'h4A5);
        chk("add_instr", 64'(a0.ex_instr), 64'hC0FFEEA5);

        a0.fwd_data = {32'd100, 32'd55};
        a0.fwd_selA = 2'd2;
        q0.push_back(64'd107);
        #1;
        sb0("add_fwdA");
        a0.fwd_selA = 2'd0;

        load0(ALU_ADD, SRC_RT, 32'd1, 32'd2, 32'd0, 32'd0, 8'h11);
        a0.fwd_selB = 2'd1;
        q0.push_back(64'd56);
        step();
        a0.exen = 1'b0;
        sb0("add_fwdB");
        chk("store_fwd", 64'(a0.ex_store), 64'd55);
        a0.fwd_selB = 2'd0;
        #1;
        chk("store_rt", 64'(a0.ex_store), 64'd2);

        load0(ALU_SUB, SRC_RT, 32'd3, 32'd3, 32'd0, 32'd0, 8'h12);
        q0.push_back(64'd0);
        step();
        sb0("sub");

        load0(ALU_SLT, SRC_RT, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 8'h13);
        q0.push_back(64'd1);
        step();
        sb0("slt");

        load0(ALU_SLTU, SRC_RT, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 8'h14);
        q0.push_back(64'd0);
        step();
        sb0("sltu");

        load0(ALU_SRA, SRC_SHAMT, 32'h80000000, 32'd0, 32'd0, 32'd4, 8'h15);
        q0.push_back(64'hF8000000);
        step();
        sb0("sra");

        load0(ALU_OR, SRC_ZERO, 32'h1234, 32'h55, 32'h77, 32'd0, 8'h16);
        q0.push_back(64'h1234);
        step();
        a0.exen = 1'b0;
        sb0("src_zero");

        load0(ALU_MUL, SRC_RT, 32'h10000, 32'h10000, 32'd0, 32'd0, 8'h3C);
        q0.push_back(64'd0);
        step();
        chk("mul_busy0",  64'(a0.ex_busy),  64'd1);
        chk("mul_valid0", 64'(a0.ex_valid), 64'd0);
        a0.id_rs   = 32'd99;
        a0.id_ctrl = 8'hEE;
        step();
        a0.fwd_data = {32'd100, 32'd7};
        a0.fwd_selA = 2'd1;
        #1;
        chk("mul_busy1", 64'(a0.ex_busy), 64'd1);
        step();
        chk("mul_busy2", 64'(a0.ex_busy), 64'd1);
        step();
        chk("mul_busy3", 64'(a0.ex_busy), 64'd0);
        sb0("mul");
        chk("mul_ctrl", 64'(a0.ex_ctrl), 64'h3C);
        a0.exen     = 1'b0;
        a0.fwd_selA = 2'd0;

        load0(ALU_MUL, SRC_IMM, 32'd123, 32'd0, 32'd456, 32'd0, 8'h21);
        q0.push_back(64'd56088);
        step();
        a0.exen = 1'b0;
        busy_n  = 0;
        for (int i = 0; i < 10 && !a0.ex_valid; i++) begin
            if (a0.ex_busy) busy_n++;
            step();
        end
        chk("mul2_busy_cycles", 64'(busy_n), 64'd3);
        sb0("mul2");

        load0(ALU_MUL, SRC_RT, 32'd5, 32'd6, 32'd0, 32'd0, 8'h5A);
        step();
        step();
        chk("fl_busy_pre", 64'(a0.ex_busy), 64'd1);
        a0.flush = 1'b1;
        load0(ALU_ADD, SRC_IMM, 32'd1, 32'd0, 32'd1, 32'd0, 8'h77);
        step();
        a0.flush = 1'b0;
        a0.exen  = 1'b0;
        #1;
        chk("fl_busy",  64'(a0.ex_busy),  64'd0);
        chk("fl_valid", 64'(a0.ex_valid), 64'd0);
        chk("fl_ctrl",  64'(a0.ex_ctrl),  64'd0);

        load0(ALU_XOR, SRC_RT, 32'hF0, 32'h0F, 32'd0, 32'd0, 8'h31);
        q0.push_back(64'hFF);
        step();
        a0.exen = 1'b0;
        sb0("post_flush");

        load1(ALU_MUL, 16'd300, 16'd300);
        q1.push_back(64'h5F90);
        step();
        a1.exen = 1'b0;
        chk("mul16_busy", 64'(a1.ex_busy), 64'd0);
        sb1("mul16");
        a1.fwd_data = {16'd2, 16'd9, 16'd8};
        a1.fwd_selB = 2'd3;
        q1.push_back(64'd600);
        #1;
        sb1("mul16_fwdB");
        chk("store16_fwd", 64'(a1.ex_store), 64'd2);

        chk("q0_drained", 64'(q0.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_mc.md
# execute_mc

Parametrised, multi-cycle-capable execute stage for the 5-stage pipeline, placed between decode and memory. It holds the ID/EX pipeline register and selects operands, including forwarded values from `NFWD` later-stage sources. Single-cycle ops go through a parametrised ALU. `ALU_MUL` runs on an iterative multiplier that stalls the pipeline through `ex_busy`. Compared with the fixed 32-bit stage it replaces, it adds data-width generality, N-way forwarding, a fully defined operand mux and multiply support.

## Interface
Parameters:
- `DW`, 32, datapath width (power of two, ≥8)
- `CW`, 8, width of pass-through control bundle (dREN, dWEN, regWr, regSel, regDst, halt, lui, …)
- `NFWD`, 2, number of forwarding sources
- `MUL_LAT`, 4, multiply latency in cycles (≥1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `CLK` in 1 — clock
  - `RST` in 1 — asynchronous, active-high reset
- Pipeline control:
  - `flush` in 1 — squash ID/EX contents
  - `exen` in 1 — load ID/EX register
- Decode-stage inputs:
  - `id_valid` in 1 — decode slot holds a real instruction
  - `id_rs` in DW — rs operand
  - `id_rt` in DW — rt operand
  - `id_imm` in DW — extended immediate
  - `id_shamt` in DW — zero-extended shamt
  - `id_alusrc` in 2 — operand-B source (`alusrc_e`)
  - `id_aluop` in 4 — operation (`aluop_e`)
  - `id_ctrl` in CW — control bundle
  - `id_npc` in DW — next PC
  - `id_instr` in 32 — instruction word
- Forwarding:
  - `fwd_data` in NFWD*DW — forwarded values; source k occupies bits [k*DW +: DW]
  - `fwd_selA` in $clog2(NFWD+1) — forwarding select for A; 0 = none, k = source k-1
  - `fwd_selB` in $clog2(NFWD+1) — forwarding select for B; 0 = none, k = source k-1
- Outputs:
  - `ex_valid` out 1 — stage output is a completed, real instruction
  - `ex_busy` out 1 — multiply in progress; upstream must stall
  - `ex_result` out DW — ALU or multiply result
  - `ex_zero` out 1 — `ex_result == 0`
  - `ex_store` out DW — rt value after forwarding (store data)
  - `ex_ctrl` out CW — registered control bundle
  - `ex_npc` out DW — registered next PC
  - `ex_instr` out 32 — registered instruction word

## Operation
- ID/EX register update, in priority order:
  - `RST`: clear the register.
  - `flush`: clear the register.
  - `exen && !ex_busy`: load all `id_*` fields.
  - Otherwise: hold.
- Cleared state:
  - All fields zero.
  - `aluop = ALU_ADD`.
  - `alusrc = SRC_RT`.
  - Valid bit 0.
- Operand A = `fwd_selA != 0` ? source `fwd_selA-1` : registered rs.
- Operand B:
  - rt-value = `fwd_selB != 0` ? forwarded source : registered rt.
  - B is chosen by alusrc:
    - `SRC_RT` → rt-value
    - `SRC_IMM` → imm
    - `SRC_SHAMT` → shamt
    - `SRC_ZERO` (2'd3) → 0
  - No latches; every case assigned.
  - `ex_store` = rt-value.
- ALU ops (mod 2^DW):
  - ADD, SUB, AND, OR, XOR, NOR
  - SLL, SRL, SRA: shift A by B[$clog2(DW)-1:0]
  - SLT: signed compare
  - SLTU: unsigned compare
  - MUL: low DW bits of A*B
  - Undefined opcodes give result 0.
- Multiplier FSM states: `IDLE`, `RUN`, `DONE`.
  - IDLE→RUN: the register holds valid `ALU_MUL` and `MUL_LAT>1`. On this entry cycle the FSM captures forwarded A/B into internal operand registers and loads the counter with `MUL_LAT-1`.
  - RUN: decrement the counter each cycle. Move to DONE when it reaches 1.
  - DONE: drive the product. Return to IDLE on the next register load or flush.
- `ex_busy` = (valid MUL held and FSM in IDLE with `MUL_LAT>1`) or FSM in RUN. It is a combinational output.
- `ex_valid` = valid bit && !`ex_busy`.
- With `MUL_LAT=1`, MUL completes in one cycle like any ALU op, and `ex_busy` never asserts.
- A flush in any FSM state aborts the multiply. The FSM and counter return to IDLE and `ex_busy` drops the next cycle.

## Timing
- Non-MUL op: loaded at edge N; `ex_result` is valid combinationally during cycle N (same as ALU).
- MUL loaded at edge N:
  - `ex_busy` is high during cycles N … N+MUL_LAT-2.
  - `ex_result` and `ex_valid` are valid in cycle N+MUL_LAT-1.
- `exen` is ignored while `ex_busy` is high; a simultaneous `flush` wins.
- Forwarding inputs are sampled combinationally for non-MUL ops. MUL sources them only in the entry cycle.
- Reset values of registered outputs: `ex_ctrl`, `ex_npc`, `ex_instr` = 0.
- Reset values of derived outputs: `ex_valid` = 0, `ex_busy` = 0, `ex_result` = 0, `ex_zero` = 1, `ex_store` = 0 (with forwarding selects 0).
- `RST` asserted mid-multiply clears the FSM immediately.

## Structure
- Shared package `exec_pkg`:
  - `aluop_e`: ADD, SUB, AND, OR, XOR, NOR, SLL, SRL, SRA, SLT, SLTU, MUL
  - `alusrc_e`: SRC_RT, SRC_IMM, SRC_SHAMT, SRC_ZERO
  - `FWD_NONE = 0`
- Sub-module `exec_alu`: combinational, parametrised by `DW`, covering all non-MUL ops.
- The multiply FSM and operand mux live in `execute_mc`.

## Test plan
- Reset, then release with `exen=0`: `ex_valid=0`, `ex_busy=0`, `ex_result=0`, `ex_zero=1`, `ex_ctrl=0`.
- Load ADD with rs=5 and imm=7 (`SRC_IMM`) at DW=32 → `ex_result=12`, `ex_valid=1` in the same cycle. Then `fwd_selA=2` with source 1 = 100 → `ex_result=107`.
- SUB with rs=3, rt=3 → `ex_zero=1`. SLT with rs=0xFFFFFFFF, rt=1 → 1. SLTU on the same operands → 0. SRA of 0x80000000 by shamt 4 → 0xF8000000.
- MUL 0x10000*0x10000 with `MUL_LAT=4` → `ex_busy` high for 3 cycles with `exen` held 1 and no reload; then `ex_result=0`, `ex_valid=1`. Forwarding changed mid-multiply does not affect the result.
- Flush in the 2nd busy cycle of a MUL → next cycle `ex_busy=0`, `ex_valid=0`, `ex_ctrl=0`. A simultaneous `exen` does not load.
- Rebuild with DW=16, NFWD=3, MUL_LAT=1: MUL 300*300 → 0x5F90 in one cycle with no busy. `fwd_selB=3` selects source 2.
